// File: rtl/of_pkg.sv
// Shared constants, types and helpers for the operand-fetch stage.
package of_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NREGS  = 1 << ADDR_W;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic              wen;
  } of_issue_t;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } of_operands_t;

  // Saturating increment for the stall counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic en);
    logic [15:0] result;
    if (en && (value != STALL_MAX)) begin
      result = value + 16'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/of_if.sv
// Handshake, register-file and write-back signals of the operand-fetch stage.
interface of_if
  import of_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int addr_width = ADDR_W
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [addr_width-1:0] in_rs1;
  logic [addr_width-1:0] in_rs2;
  logic [addr_width-1:0] in_rd;
  logic                  in_wen;
  logic [addr_width-1:0] read_addr1;
  logic [addr_width-1:0] read_addr2;
  logic [data_width-1:0] read_data1;
  logic [data_width-1:0] read_data2;
  logic                  we;
  logic [addr_width-1:0] wr_addr;
  logic [data_width-1:0] wr_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_op1;
  logic [data_width-1:0] out_op2;
  logic [addr_width-1:0] out_rd;
  logic                  out_wen;
  logic [15:0]           stall_cycles;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_wen,
    output read_data1, read_data2,
    output we, wr_addr, wr_data,
    output out_ready,
    input  in_ready, read_addr1, read_addr2,
    input  out_valid, out_op1, out_op2, out_rd, out_wen, stall_cycles
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_wen,
    input  read_data1, read_data2,
    input  we, wr_addr, wr_data,
    input  out_ready,
    output in_ready, read_addr1, read_addr2,
    output out_valid, out_op1, out_op2, out_rd, out_wen, stall_cycles
  );

endinterface

// File: rtl/of_scoreboard.sv
// Per-register pending-write scoreboard with write-back-masked lookups.
module of_scoreboard
  import of_pkg::*;
#(
  parameter int addr_width = ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [addr_width-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [addr_width-1:0] clr_addr,
  input  logic [addr_width-1:0] look1,
  input  logic [addr_width-1:0] look2,
  input  logic [addr_width-1:0] look3,
  output logic                  pend1,
  output logic                  pend2,
  output logic                  pend3
);

  localparam int nregs = 1 << addr_width;

  logic [nregs-1:0] busy_r;
  logic [nregs-1:0] busy_s;

  // A register stays pending unless this cycle's write-back retires it.
  function automatic logic pending(input logic [nregs-1:0] busy, input logic [addr_width-1:0] addr,
                                   input logic hit_en, input logic [addr_width-1:0] hit_addr);
    return busy[addr] && !(hit_en && (hit_addr == addr));
  endfunction

  assign pend1 = pending(busy_r, look1, clr_en, clr_addr);
  assign pend2 = pending(busy_r, look2, clr_en, clr_addr);
  assign pend3 = pending(busy_r, look3, clr_en, clr_addr);

  // Next scoreboard: clear on write-back, then set on issue (set wins).
  always_comb begin
    busy_s = busy_r;
    for (int i = 0; i < nregs; i++) begin
      busy_s[i] = (set_en && (set_addr == addr_width'(i))) ? 1'b1 :
                  (clr_en && (clr_addr == addr_width'(i))) ? 1'b0 : busy_r[i];
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_s;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: hazard-checked issue, write-back bypass and a one-deep output register.
module operand_fetch
  import of_pkg::*;
#(
  parameter int data_width = DATA_W,
  parameter int addr_width = ADDR_W
) (
  input  logic clk,
  input  logic reset,
  of_if.slave  bus
);

  logic                  raw1_s;
  logic                  raw2_s;
  logic                  rd_busy_s;
  logic                  hazard_s;
  logic                  ready_s;
  logic                  fire_s;
  logic                  hit1_s;
  logic                  hit2_s;
  logic [data_width-1:0] op1_s;
  logic [data_width-1:0] op2_s;

  logic                  out_valid_r;
  logic [data_width-1:0] op1_r;
  logic [data_width-1:0] op2_r;
  logic [addr_width-1:0] rd_r;
  logic                  wen_r;
  logic [15:0]           stall_r;

  assign bus.read_addr1 = bus.in_rs1;
  assign bus.read_addr2 = bus.in_rs2;

  of_scoreboard #(.addr_width(addr_width)) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (fire_s && bus.in_wen),
    .set_addr (bus.in_rd),
    .clr_en   (bus.we),
    .clr_addr (bus.wr_addr),
    .look1    (bus.in_rs1),
    .look2    (bus.in_rs2),
    .look3    (bus.in_rd),
    .pend1    (raw1_s),
    .pend2    (raw2_s),
    .pend3    (rd_busy_s)
  );

  assign hazard_s = raw1_s || raw2_s || (bus.in_wen && rd_busy_s);
  assign ready_s  = !hazard_s && (!out_valid_r || bus.out_ready);
  assign fire_s   = bus.in_valid && ready_s;

  // reg_file only shows a write the cycle after we, so forward wr_data here.
  assign hit1_s = bus.we && (bus.wr_addr == bus.in_rs1);
  assign hit2_s = bus.we && (bus.wr_addr == bus.in_rs2);
  assign op1_s  = hit1_s ? bus.wr_data : bus.read_data1;
  assign op2_s  = hit2_s ? bus.wr_data : bus.read_data2;

  // Output register: load on fire, drop valid on a drain with no refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      op1_r       <= '0;
      op2_r       <= '0;
      rd_r        <= '0;
      wen_r       <= 1'b0;
    end else if (fire_s) begin
      out_valid_r <= 1'b1;
      op1_r       <= op1_s;
      op2_r       <= op2_s;
      rd_r        <= bus.in_rd;
      wen_r       <= bus.in_wen;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Hazard stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_r <= 16'd0;
    end else begin
      stall_r <= sat_inc(stall_r, bus.in_valid && hazard_s);
    end
  end

  assign bus.in_ready     = ready_s;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_op1      = op1_r;
  assign bus.out_op2      = op2_r;
  assign bus.out_rd       = rd_r;
  assign bus.out_wen      = wen_r;
  assign bus.stall_cycles = stall_r;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

- Operand-fetch stage directly downstream of `reg_file`.
- Accepts decoded register specifiers over a valid/ready handshake and drives `reg_file` read addresses combinationally.
- Captures both operands into a one-deep output register, bypassing same-cycle write-back data, since `reg_file` writes only appear the cycle after `we`.
- A per-register scoreboard stalls issue on RAW/WAW hazards against writes still in flight.

## Interface
Parameters:
- `data_width`, 32, operand/write data width
- `addr_width`, 4, register address width; 2**addr_width registers tracked

Ports:
- `clk`  in  1  clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream has an instruction
- `in_ready`  out  1  stage accepts this cycle
- `in_rs1`, `in_rs2`  in  addr_width  source register specifiers
- `in_rd`  in  addr_width  destination register
- `in_wen`  in  1  instruction will write `in_rd`
- `read_addr1`, `read_addr2`  out  addr_width  to `reg_file`
- `read_data1`, `read_data2`  in  data_width  from `reg_file` (combinational)
- `we`  in  1  write-back enable (same net as `reg_file` `we`)
- `wr_addr`  in  addr_width  write-back address
- `wr_data`  in  data_width  write-back data
- `out_valid`  out  1  output register holds an instruction
- `out_ready`  in  1  downstream accepts
- `out_op1`, `out_op2`  out  data_width  captured operands
- `out_rd`  out  addr_width  captured destination
- `out_wen`  out  1  captured write flag
- `stall_cycles`  out  16  saturating hazard-stall counter

## Operation
- `read_addr1 = in_rs1` and `read_addr2 = in_rs2`, combinational and unconditional.
- `busy[r]`: scoreboard bit, set when `r` is owed a write.
- `wb_hit(r) = we && wr_addr == r`.
- Hazard conditions:
  - `raw1 = busy[in_rs1] && !wb_hit(in_rs1)`
  - `raw2 = busy[in_rs2] && !wb_hit(in_rs2)`
  - `waw = in_wen && busy[in_rd] && !wb_hit(in_rd)`
  - `hazard = raw1 || raw2 || waw`
- `in_ready = !hazard && (!out_valid || out_ready)`. `in_ready` does not depend on `in_valid`.
- `fire = in_valid && in_ready`.
- On `fire`, the output register loads:
  - `out_op1` = `wr_data` if `wb_hit(in_rs1)`, else `read_data1`
  - `out_op2` = same rule using `in_rs2` / `read_data2`
  - `out_rd`, `out_wen`
  - `out_valid` is set to 1.
- `out_valid && out_ready && !fire` clears `out_valid`. Data fields hold their last values.
- `out_valid && !out_ready`: all output fields hold.
- Scoreboard update, applied in order within one cycle:
  1. if `we`, clear `busy[wr_addr]`
  2. if `fire && in_wen`, set `busy[in_rd]`
  - Set wins on the same index.
- A write-back to a non-busy register is legal and has no scoreboard effect.
- Register 0 is an ordinary register: it is tracked and not hardwired to zero.
- `stall_cycles` increments on every cycle with `in_valid && hazard` and saturates at 16'hFFFF.

## Timing
- Reset values: `out_valid` 0, `out_op1`/`out_op2` 0, `out_rd` 0, `out_wen` 0, all `busy` 0, `stall_cycles` 0.
- `in_ready` becomes 1 the cycle after reset deasserts, provided there is no hazard.
- Reset asserted mid-operation discards the output register and the scoreboard in the same edge. In-flight write-backs after reset are ignored by the scoreboard, since their bits are already clear.
- Latency: `fire` at edge N gives `out_valid` = 1 after edge N.
- Throughput: one instruction per cycle while `out_ready` = 1 and there is no hazard.
- A hazard clears in the cycle of the matching `we`: `in_ready` rises combinationally that cycle, with the operand bypassed from `wr_data`.
- Back-to-back dependent instructions stall until write-back; there is no ALU forwarding in this stage.

## Structure
- Package `of_pkg`:
  - `DATA_W`, `ADDR_W`, `NREGS` constants
  - `of_issue_t` packed struct {rd, wen}
  - `of_operands_t` packed struct {op1, op2}
- Sub-module `of_scoreboard`:
  - `busy` vector with set/clear ports
  - three combinational lookup ports, each with write-back hit masking
- The top level holds the handshake, the bypass muxes, the output register and the stall counter.

## Test plan
- **Reset and basic read:** preload reg 3 = 32'd23 and reg 4 = 32'd4 through `we`; issue rs1=3, rs2=4, rd=5, wen=1 with `out_ready`=1 -> next cycle `out_valid`=1, op1=23, op2=4, `busy[5]`=1.
- **RAW stall then bypass:** after the above, issue rs1=5. Expect `in_ready`=0 and `stall_cycles` to increment each cycle. Then drive `we`=1, wr_addr=5, wr_data=32'd99 for one cycle -> `in_ready`=1 that cycle, op1=99 captured, `busy[5]` cleared.
- **Same-cycle clear and set:** `busy[6]`=1; in one cycle drive `we` to addr 6 and issue an instruction with rd=6, wen=1 -> fire occurs and `busy[6]` remains 1.
- **Backpressure:** hold `out_ready`=0 with `out_valid`=1 -> `in_ready`=0 and outputs stable for 3 cycles. Raise `out_ready` -> a queued instruction fires in the same cycle.
- **Stall counter saturation:** hold a RAW hazard for 65540 cycles -> `stall_cycles`=16'hFFFF and stays there.
- **Reset mid-operation:** `out_valid`=1 and `busy[2]`=1; assert `reset` for one cycle -> `out_valid`=0, all `busy` 0, `stall_cycles`=0.
